pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised successor to the core's program counter register: holds the fetch PC and computes the next PC.
- Next-PC sources: sequential, branch-relative, absolute jump, register jump, return-address pop, exception vector and exception return.
- Contains a small circular return-address stack (RAS) and an exception PC register (EPC).
- Sits between the control unit / branch logic and instruction memory. pc_out drives the instruction-memory address.

Parameters:
- ADDR_WIDTH, 13: width of the PC and every internal address.
- RESET_VECTOR, 0: PC value loaded on reset.
- EXC_VECTOR, 'h100: PC value loaded on exception.
- RAS_DEPTH, 4: number of RAS entries; must be a power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- pc_write  in  1  PC update enable; low = stall
- pc_sel  in  3  next-PC source select
- branch_offset  in  32  sign-extended word offset
- jump_target  in  32  absolute jump byte address
- reg_target  in  32  register-jump byte address
- push_ret  in  1  push link address (pc_out+4) onto the RAS
- exception  in  1  take exception
- eret  in  1  return from exception
- pc_out  out  ADDR_WIDTH  current PC
- pc_plus4  out  ADDR_WIDTH  pc_out+4, combinational
- epc_out  out  ADDR_WIDTH  saved exception PC
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_overflow  out  1  sticky; a push occurred while the RAS was full
- ras_underflow  out  1  one-cycle pulse; a RET was selected while the RAS was empty
- misaligned  out  1  one-cycle pulse; the selected target had nonzero bits [1:0]

Behaviour:
- Reset: all state and outputs are registered and updated on the rising edge of clk. When reset=0 at an edge:
  - pc_out=RESET_VECTOR, epc_out=0, RAS count=0.
  - ras_empty=1, ras_full=0, ras_overflow=0, ras_underflow=0, misaligned=0.
  - Reset overrides every other input, including mid-sequence.
- Arithmetic: all address arithmetic is modulo 2^ADDR_WIDTH. Wider inputs are truncated to [ADDR_WIDTH-1:0] after any arithmetic; wrap-around is silent.
- Priority per edge: reset > exception > eret > pc_write.
  - exception: epc_out<=pc_out; pc_out<=EXC_VECTOR. Taken regardless of pc_write. RAS untouched; push_ret ignored.
  - eret (no exception): pc_out<=epc_out. Taken regardless of pc_write. RAS untouched.
  - pc_write=0: pc_out, RAS and epc_out hold. Pulse outputs go to 0.
- pc_write=1, next PC by pc_sel:
  - 0 SEQ: pc_out+4.
  - 1 BRANCH: pc_out+4+(branch_offset<<2).
  - 2 JUMP: jump_target.
  - 3 JR: reg_target.
  - 4 RET: RAS top entry, which is popped. If the RAS is empty: pc_out+4 and ras_underflow=1 for one cycle.
  - 5-7: treated as SEQ.
- Misalignment: if a JUMP or JR target has bits [1:0]≠0, the loaded PC has bits [1:0] forced to 0 and misaligned=1 for one cycle. BRANCH and RET results are aligned by construction.
- Push (pc_write=1 and push_ret=1): pc_out+4 is written to the top of the RAS.
  - If the RAS is full, the oldest entry is overwritten (circular pointer), the count stays at RAS_DEPTH, and ras_overflow is set. ras_overflow is cleared only by reset.
- Push with RET in the same cycle: the pop supplies the next PC first, then the push writes pc_out+4 into the same slot. The count is unchanged.
  - If the RAS was empty: underflow handling applies (next PC pc_out+4, ras_underflow pulse), then the push occurs and the count becomes 1.
- Latency: pc_out reflects a decision one cycle after the edge at which the inputs are sampled. There is no combinational path from inputs to pc_out.
- RAS flags: ras_empty and ras_full are derived combinationally from the registered count.

Decomposition:
- Package musa_pc_pkg holds:
  - the PC_SEL_SEQ/BRANCH/JUMP/JR/RET encodings (3 bits);
  - the link increment constant 4.
- One sub-module, pc_ras: circular LIFO with parameters ADDR_WIDTH and RAS_DEPTH.
  - Inputs: push, pop, din.
  - Outputs: top, empty, full, overflow_set.
- pc_unit contains the next-PC mux, the PC register, the EPC register and the flag registers.

Test Plan:
- Reset then SEQ: reset=0 for one cycle, then pc_write=1, sel=0 for 3 cycles -> pc_out 0, 4, 8, 12. With pc_write=0 -> holds at 12.
- Branch wrap: pc_out=0x1FFC, sel=1, offset=0 -> 0x0000. pc_out=0x0010, offset=0xFFFFFFFE -> 0x000C.
- JR misaligned: sel=3, reg_target=0x0000_0123 -> pc_out=0x0120 and misaligned pulses for exactly one cycle.
- RAS: with RAS_DEPTH=4, push_ret with JUMP at pc=0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1 after the 4th push and ras_overflow=1 after the 5th. Four RETs then return 0x54, 0x44, 0x34, 0x24. A 5th RET gives ras_underflow=1 and next PC pc_out+4.
- Exception: at pc=0x0040, exception=1 with pc_write=0 -> pc_out=0x100, epc_out=0x040. eret -> pc_out=0x040. Exception and eret asserted together -> exception wins.
- Reset mid-operation: with 2 RAS entries and ras_overflow=1, assert reset=0 -> pc_out=RESET_VECTOR, ras_empty=1, ras_overflow=0, epc_out=0.

Source files
------------

// File: rtl/musa_pc_pkg.sv
`default_nettype none
// ============================================================================
// Module : musa_pc_pkg
// Brief  : Next-PC source encodings and link increment shared by the PC unit.
// Rev    : 1.0  initial release
// ============================================================================
package musa_pc_pkg;

    localparam logic [2:0] PC_SEL_SEQ    = 3'd0;
    localparam logic [2:0] PC_SEL_BRANCH = 3'd1;
    localparam logic [2:0] PC_SEL_JUMP   = 3'd2;
    localparam logic [2:0] PC_SEL_JR     = 3'd3;
    localparam logic [2:0] PC_SEL_RET    = 3'd4;

    localparam int unsigned PC_LINK_INC = 4;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module : pc_ras
// Brief  : Circular return-address stack; a push when full overwrites the oldest.
// Rev    : 1.0  initial release
// ============================================================================
module pc_ras #(
    parameter int ADDR_WIDTH = 13,
    parameter int RAS_DEPTH  = 4     // power of two, >= 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] din,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow_set
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      r_ptr;      // next free slot; wraps over the oldest
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      w_topIdx;
    logic                  w_doPop;

    assign w_topIdx     = r_ptr - PTR_W'(1);
    assign empty        = (r_count == '0);
    assign full         = (r_count == CNT_W'(RAS_DEPTH));
    assign top          = r_mem[w_topIdx];
    assign w_doPop      = pop && !empty;
    assign overflow_set = push && full && !w_doPop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push && w_doPop) begin
            r_ptr   <= r_ptr;
        end else if (push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (!full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_doPop) begin
            r_ptr   <= w_topIdx;
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Push+pop reuses the slot just popped, so the depth does not change.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            if (w_doPop) begin
                r_mem[w_topIdx] <= din;
            end else begin
                r_mem[r_ptr] <= din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module : pc_unit
// Brief  : Fetch PC register with next-PC mux, return-address stack and EPC.
// Rev    : 1.0  initial release
// ============================================================================
module pc_unit
    import musa_pc_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 13,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned EXC_VECTOR   = 'h100,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_write,
    input  logic [2:0]            pc_sel,
    input  logic [31:0]           branch_offset,
    input  logic [31:0]           jump_target,
    input  logic [31:0]           reg_target,
    input  logic                  push_ret,
    input  logic                  exception,
    input  logic                  eret,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic [ADDR_WIDTH-1:0] epc_out,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_overflow,
    output logic                  ras_underflow,
    output logic                  misaligned
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_epc;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_misaligned;

    logic [ADDR_WIDTH-1:0] w_pcPlus4;
    logic [31:0]           w_offShift;
    logic [ADDR_WIDTH-1:0] w_nextPc;
    logic [ADDR_WIDTH-1:0] w_nextEpc;
    logic                  w_misaligned;
    logic                  w_underflow;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_rasTop;
    logic                  w_rasEmpty;
    logic                  w_rasFull;
    logic                  w_overflowSet;

    assign w_pcPlus4  = r_pc + ADDR_WIDTH'(PC_LINK_INC);
    assign w_offShift = branch_offset << 2;

    // Upper input bits beyond the address width are intentionally dropped.
    if (ADDR_WIDTH < 32) begin : g_unusedHi
        logic w_unused;
        assign w_unused = ^{w_offShift[31:ADDR_WIDTH], jump_target[31:ADDR_WIDTH],
                            reg_target[31:ADDR_WIDTH]};
    end

    always_comb begin
        w_nextPc     = r_pc;
        w_nextEpc    = r_epc;
        w_misaligned = 1'b0;
        w_underflow  = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        if (exception) begin
            w_nextPc  = ADDR_WIDTH'(EXC_VECTOR);
            w_nextEpc = r_pc;
        end else if (eret) begin
            w_nextPc = r_epc;
        end else if (pc_write) begin
            w_push = push_ret;
            case (pc_sel)
                PC_SEL_BRANCH: w_nextPc = w_pcPlus4 + w_offShift[ADDR_WIDTH-1:0];
                PC_SEL_JUMP: begin
                    w_nextPc     = {jump_target[ADDR_WIDTH-1:2], 2'b00};
                    w_misaligned = |jump_target[1:0];
                end
                PC_SEL_JR: begin
                    w_nextPc     = {reg_target[ADDR_WIDTH-1:2], 2'b00};
                    w_misaligned = |reg_target[1:0];
                end
                PC_SEL_RET: begin
                    w_pop = 1'b1;
                    if (w_rasEmpty) begin
                        w_nextPc    = w_pcPlus4;
                        w_underflow = 1'b1;
                    end else begin
                        w_nextPc = w_rasTop;
                    end
                end
                default: w_nextPc = w_pcPlus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc         <= ADDR_WIDTH'(RESET_VECTOR);
            r_epc        <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_nextPc;
            r_epc        <= w_nextEpc;
            r_overflow   <= r_overflow | w_overflowSet;
            r_underflow  <= w_underflow;
            r_misaligned <= w_misaligned;
        end
    end

    pc_ras #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk          (clk),
        .reset        (reset),
        .push         (w_push),
        .pop          (w_pop),
        .din          (w_pcPlus4),
        .top          (w_rasTop),
        .empty        (w_rasEmpty),
        .full         (w_rasFull),
        .overflow_set (w_overflowSet)
    );

    assign pc_out        = r_pc;
    assign pc_plus4      = w_pcPlus4;
    assign epc_out       = r_epc;
    assign ras_empty     = w_rasEmpty;
    assign ras_full      = w_rasFull;
    assign ras_overflow  = r_overflow;
    assign ras_underflow = r_underflow;
    assign misaligned    = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_unit
// Brief  : Directed bench for pc_unit with a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pc_unit;

    localparam int          AW    = 13;
    localparam int unsigned MASK  = (1 << AW) - 1;
    localparam int unsigned EXC   = 'h100;
    localparam int          DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pc_write = 1'b0;
    logic [2:0]    pc_sel = 3'd0;
    logic [31:0]   branch_offset = '0;
    logic [31:0]   jump_target = '0;
    logic [31:0]   reg_target = '0;
    logic          push_ret = 1'b0;
    logic          exception = 1'b0;
    logic          eret = 1'b0;
    logic [AW-1:0] pc_out, pc_plus4, epc_out;
    logic          ras_empty, ras_full, ras_overflow, ras_underflow, misaligned;

    int nCompared = 0;
    int nMismatched = 0;

    pc_unit #(
        .ADDR_WIDTH   (AW),
        .RESET_VECTOR (0),
        .EXC_VECTOR   (EXC),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .reg_target    (reg_target),
        .push_ret      (push_ret),
        .exception     (exception),
        .eret          (eret),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .epc_out       (epc_out),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers and a queue standing in for the stack.
    int unsigned mPc, mEpc;
    int unsigned mRas[$];
    bit          mOvf, mUf, mMis, mValid = 1'b0;

    always @(posedge clk) begin
        int unsigned link, nxt;
        if (!reset) begin
            mPc = 0; mEpc = 0; mRas.delete();
            mOvf = 0; mUf = 0; mMis = 0; mValid = 1;
        end else if (exception) begin
            mEpc = mPc; mPc = EXC; mUf = 0; mMis = 0;
        end else if (eret) begin
            mPc = mEpc; mUf = 0; mMis = 0;
        end else if (!pc_write) begin
            mUf = 0; mMis = 0;
        end else begin
            link = (mPc + 4) & MASK;
            mUf = 0; mMis = 0;
            case (pc_sel)
                3'd1: nxt = (mPc + 4 + (branch_offset << 2)) & MASK;
                3'd2: begin nxt = jump_target & MASK & ~32'd3; mMis = (jump_target[1:0] != 0); end
                3'd3: begin nxt = reg_target & MASK & ~32'd3;  mMis = (reg_target[1:0] != 0); end
                3'd4: begin
                    if (mRas.size() == 0) begin nxt = link; mUf = 1; end
                    else nxt = mRas.pop_back();
                end
                default: nxt = link;
            endcase
            if (push_ret) begin
                if (mRas.size() == DEPTH) begin
                    void'(mRas.pop_front());
                    mOvf = 1;
                end
                mRas.push_back(link);
            end
            mPc = nxt;
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            check("pc_out", 32'(pc_out), mPc);
            check("pc_plus4", 32'(pc_plus4), (mPc + 4) & MASK);
            check("epc_out", 32'(epc_out), mEpc);
            check("ras_empty", 32'(ras_empty), 32'(mRas.size() == 0));
            check("ras_full", 32'(ras_full), 32'(mRas.size() == DEPTH));
            check("ras_overflow", 32'(ras_overflow), 32'(mOvf));
            check("ras_underflow", 32'(ras_underflow), 32'(mUf));
            check("misaligned", 32'(misaligned), 32'(mMis));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic [2:0] sel, input logic [31:0] tgt,
                         input logic push);
        pc_write = pw; pc_sel = sel; jump_target = tgt; reg_target = tgt; push_ret = push;
        cyc();
    endtask

    initial begin
        logic [31:0] rets [4] = '{32'h54, 32'h44, 32'h34, 32'h24};

        // Reset then sequential fetch and stall
        reset = 1'b0; cyc();
        check("lit_reset_pc", 32'(pc_out), 32'h0);
        check("lit_reset_empty", 32'(ras_empty), 32'h1);
        reset = 1'b1;
        repeat (3) drive(1, 3'd0, 0, 0);
        check("lit_seq_pc", 32'(pc_out), 32'd12);
        repeat (2) drive(0, 3'd0, 0, 0);
        check("lit_stall_pc", 32'(pc_out), 32'd12);

        // Branch wrap-around and negative offset
        drive(1, 3'd2, 32'h1FFC, 0);
        branch_offset = 32'h0; drive(1, 3'd1, 0, 0);
        check("lit_branch_wrap", 32'(pc_out), 32'h0);
        drive(1, 3'd2, 32'h10, 0);
        branch_offset = 32'hFFFF_FFFE; drive(1, 3'd1, 0, 0);
        check("lit_branch_neg", 32'(pc_out), 32'hC);

        // Misaligned register jump, then pulse clears
        drive(1, 3'd3, 32'h123, 0);
        check("lit_jr_pc", 32'(pc_out), 32'h120);
        check("lit_jr_mis", 32'(misaligned), 32'h1);
        drive(1, 3'd0, 0, 0);
        check("lit_mis_clear", 32'(misaligned), 32'h0);
        drive(1, 3'd7, 0, 0);
        check("lit_sel7_seq", 32'(pc_out), 32'h128);

        // Return-address stack fill, overflow, drain, underflow
        drive(1, 3'd2, 32'h10, 0);
        for (int i = 2; i <= 5; i++) drive(1, 3'd2, 32'(i * 16), 1);
        check("lit_ras_full", 32'(ras_full), 32'h1);
        check("lit_ras_noovf", 32'(ras_overflow), 32'h0);
        drive(1, 3'd2, 32'h60, 1);
        check("lit_ras_ovf", 32'(ras_overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'd4, 0, 0);
            check("lit_ret_pc", 32'(pc_out), rets[i]);
        end
        drive(1, 3'd4, 0, 0);
        check("lit_uf_pc", 32'(pc_out), 32'h28);
        check("lit_uf_pulse", 32'(ras_underflow), 32'h1);
        drive(1, 3'd0, 0, 0);
        check("lit_uf_clear", 32'(ras_underflow), 32'h0);

        // Exception, return, and exception winning over eret
        drive(1, 3'd2, 32'h40, 0);
        pc_write = 1'b0; exception = 1'b1; cyc();
        check("lit_exc_pc", 32'(pc_out), 32'h100);
        check("lit_exc_epc", 32'(epc_out), 32'h40);
        exception = 1'b0; eret = 1'b1; cyc();
        check("lit_eret_pc", 32'(pc_out), 32'h40);
        exception = 1'b1; cyc();
        check("lit_exc_wins", 32'(pc_out), 32'h100);
        exception = 1'b0; eret = 1'b0;

        // Push together with RET, including on an empty stack
        drive(1, 3'd0, 0, 1);
        drive(1, 3'd4, 0, 1);
        check("lit_pushret_pc", 32'(pc_out), 32'h104);
        drive(1, 3'd4, 0, 0);
        check("lit_pushret_slot", 32'(pc_out), 32'h108);
        drive(1, 3'd4, 0, 1);
        check("lit_pushret_empty_uf", 32'(ras_underflow), 32'h1);
        drive(1, 3'd0, 0, 1);
        check("lit_two_entries", 32'(ras_empty), 32'h0);

        // Reset overrides everything mid-operation
        exception = 1'b1; reset = 1'b0; drive(1, 3'd4, 32'h80, 1);
        check("lit_rst_pc", 32'(pc_out), 32'h0);
        check("lit_rst_empty", 32'(ras_empty), 32'h1);
        check("lit_rst_ovf", 32'(ras_overflow), 32'h0);
        check("lit_rst_epc", 32'(epc_out), 32'h0);
        exception = 1'b0; reset = 1'b1;
        drive(1, 3'd0, 0, 0);
        check("lit_post_rst_seq", 32'(pc_out), 32'h4);
        drive(0, 3'd0, 0, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
